// File: rtl/rr_arbiter_oh_if.sv
// Request/grant bundle between requesters, the round-robin arbiter and the downstream one-hot mux.
// The arbiter takes the master side and drives the grant signals.
interface rr_arbiter_oh_if #(
    parameter int REQ_NUM = 4
);
    localparam int IDX_WIDTH = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0]   req_i;
    logic                 gnt_rdy_i;
    logic                 gnt_vld_o;
    logic [REQ_NUM-1:0]   gnt_oh_o;
    logic [IDX_WIDTH-1:0] gnt_idx_o;

    modport master (
        input  req_i,
        input  gnt_rdy_i,
        output gnt_vld_o,
        output gnt_oh_o,
        output gnt_idx_o
    );

    modport slave (
        output req_i,
        output gnt_rdy_i,
        input  gnt_vld_o,
        input  gnt_oh_o,
        input  gnt_idx_o
    );
endinterface

// File: rtl/rr_arbiter_oh.sv
// Registered round-robin arbiter with a one-hot grant that is held until accepted,
// after which priority rotates past the winner.
module rr_arbiter_oh #(
    parameter int REQ_NUM = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_oh_if.master bus
);
    localparam int IDX_WIDTH = $clog2(REQ_NUM);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] ptr;
    logic [IDX_WIDTH-1:0] next_ptr;
    logic [IDX_WIDTH-1:0] eval_ptr;
    logic [REQ_NUM-1:0]   masked;
    logic [REQ_NUM-1:0]   eval_req;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [REQ_NUM-1:0]   win_oh;
    logic                 found;

    always_comb begin
        next_ptr = (bus.gnt_idx_o == IDX_WIDTH'(REQ_NUM - 1)) ? '0 : bus.gnt_idx_o + 1'b1;
        masked   = bus.req_i & ~bus.gnt_oh_o;
        if (state == GRANT) begin
            eval_ptr = next_ptr;
            // Falling back to the unmasked vector lets a sole persistent requester win back-to-back.
            eval_req = (masked != '0) ? masked : bus.req_i;
        end else begin
            eval_ptr = ptr;
            eval_req = bus.req_i;
        end

        found    = 1'b0;
        cand_idx = '0;
        win_idx  = '0;
        win_oh   = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            cand_idx = IDX_WIDTH'((32'(eval_ptr) + i) % REQ_NUM);
            if (!found && eval_req[cand_idx]) begin
                found            = 1'b1;
                win_idx          = cand_idx;
                win_oh[cand_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.gnt_vld_o <= 1'b0;
            bus.gnt_oh_o  <= '0;
            bus.gnt_idx_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state         <= GRANT;
                        bus.gnt_vld_o <= 1'b1;
                        bus.gnt_oh_o  <= win_oh;
                        bus.gnt_idx_o <= win_idx;
                    end
                end
                GRANT: begin
                    if (bus.gnt_rdy_i) begin
                        ptr <= next_ptr;
                        if (found) begin
                            bus.gnt_oh_o  <= win_oh;
                            bus.gnt_idx_o <= win_idx;
                        end else begin
                            state         <= IDLE;
                            bus.gnt_vld_o <= 1'b0;
                            bus.gnt_oh_o  <= '0;
                            bus.gnt_idx_o <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COMM_ASSERT
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.gnt_oh_o));
    a_vld_matches_oh: assert property (@(posedge clk) disable iff (rst)
        bus.gnt_vld_o == (|bus.gnt_oh_o));
    a_idx_matches_oh: assert property (@(posedge clk) disable iff (rst)
        bus.gnt_oh_o[bus.gnt_idx_o] == bus.gnt_vld_o);
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.gnt_vld_o && !bus.gnt_rdy_i) |=> $stable(bus.gnt_oh_o));
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (bus.gnt_vld_o && !bus.gnt_rdy_i) |-> bus.req_i[bus.gnt_idx_o]);
`endif
endmodule

// File: tb/tb_rr_arbiter_oh.sv
// Scoreboard bench for rr_arbiter_oh: directed scenarios followed by randomized traffic,
// all checked against an integer-level round-robin reference model.
module tb_rr_arbiter_oh;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arbiter_oh_if #(.REQ_NUM(N)) bus ();

    rr_arbiter_oh #(.REQ_NUM(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       vld;
        logic [3:0] oh;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: pointer and current grant as plain integers (-1 = no grant).
    int m_ptr = 0;
    int m_gnt = -1;
    int m_acc = -1;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic chk_out(input string name, input logic vld, input logic [3:0] oh,
                           input logic [1:0] idx);
        chk({name, "_vld"}, 8'(bus.gnt_vld_o), 8'(vld));
        chk({name, "_oh"},  8'(bus.gnt_oh_o),  8'(oh));
        chk({name, "_idx"}, 8'(bus.gnt_idx_o), 8'(idx));
    endtask

    // Model: evaluates the arbitration rules at each edge and queues the expected outputs.
    always @(posedge clk) begin : model
        exp_t         e;
        logic [N-1:0] remaining;
        m_acc = -1;
        if (rst) begin
            m_ptr = 0;
            m_gnt = -1;
        end else if (m_gnt < 0) begin
            m_gnt = pick(bus.req_i, m_ptr);
        end else if (bus.gnt_rdy_i) begin
            m_acc     = m_gnt;
            m_ptr     = (m_gnt + 1) % N;
            remaining = bus.req_i;
            remaining[m_acc] = 1'b0;
            m_gnt = pick(remaining, m_ptr);
            if (m_gnt < 0 && bus.req_i[m_acc]) m_gnt = m_acc;
        end
        e.vld = (m_gnt >= 0);
        e.oh  = e.vld ? 4'(1 << m_gnt) : 4'b0000;
        e.idx = e.vld ? 2'(m_gnt) : 2'd0;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_vld", 8'(bus.gnt_vld_o), 8'(e.vld));
            chk("sb_oh",  8'(bus.gnt_oh_o),  8'(e.oh));
            chk("sb_idx", 8'(bus.gnt_idx_o), 8'(e.idx));
        end
    end

    initial begin
        logic [3:0] rr_seq [4];
        rr_seq[0] = 4'b0010;
        rr_seq[1] = 4'b0100;
        rr_seq[2] = 4'b1000;
        rr_seq[3] = 4'b0001;

        // Reset with all requests pending.
        rst           = 1'b1;
        bus.req_i     = 4'b1111;
        bus.gnt_rdy_i = 1'b0;
        @(negedge clk);
        chk_out("rst_hold", 1'b0, 4'b0000, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_out("first_grant", 1'b1, 4'b0001, 2'd0);

        // Full rotation with continuous accept.
        bus.gnt_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_out("rotate", 1'b1, rr_seq[k], 2'((k + 1) % 4));
        end

        // Stall holds the grant.
        bus.req_i = 4'b1010;
        @(negedge clk);
        chk_out("pre_stall", 1'b1, 4'b0010, 2'd1);
        bus.gnt_rdy_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_out("stall", 1'b1, 4'b0010, 2'd1);
        end
        bus.gnt_rdy_i = 1'b1;
        @(negedge clk);
        chk_out("post_stall", 1'b1, 4'b1000, 2'd3);

        // Pointer wrap after index 3.
        bus.req_i = 4'b1001;
        @(negedge clk);
        chk_out("wrap", 1'b1, 4'b0001, 2'd0);
        @(negedge clk);
        chk_out("after_wrap", 1'b1, 4'b1000, 2'd3);

        // Sole persistent requester, then drop to idle.
        bus.req_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_out("sole", 1'b1, 4'b0100, 2'd2);
        end
        bus.req_i = 4'b0000;
        @(negedge clk);
        chk_out("drop_idle", 1'b0, 4'b0000, 2'd0);
        @(negedge clk);
        chk_out("rdy_in_idle", 1'b0, 4'b0000, 2'd0);

        // Reset in the middle of a stalled grant.
        bus.req_i     = 4'b1000;
        bus.gnt_rdy_i = 1'b0;
        @(negedge clk);
        chk_out("pre_reset", 1'b1, 4'b1000, 2'd3);
        rst = 1'b1;
        @(negedge clk);
        chk_out("mid_reset", 1'b0, 4'b0000, 2'd0);
        rst       = 1'b0;
        bus.req_i = 4'b0110;
        @(negedge clk);
        chk_out("post_reset", 1'b1, 4'b0010, 2'd1);

        // Random traffic: requesters hold until accepted, then may retire or re-request.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r;
            @(posedge clk); #1;
            r = bus.req_i;
            if (m_acc >= 0 && $urandom_range(0, 3) != 0) r[m_acc] = 1'b0;
            r = r | (4'($urandom) & 4'($urandom) & 4'($urandom));
            bus.req_i     = r;
            bus.gnt_rdy_i = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
